// File: rtl/param_regfile_pkg.sv
// Shared definitions for param_regfile.
// - clr_state_e : clear-sequencer states.
// - merge_bytes : replaces the bytes of an old word that are selected by the byte enables.
//   It works on a fixed maximum width. Callers zero-extend their operands into it and
//   truncate the result back to their own width.
package param_regfile_pkg;

  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } clr_state_e;

  // Widest word merge_bytes can handle. Register-file widths must not exceed it.
  localparam int unsigned MaxWidth = 1024;
  localparam int unsigned MaxBytes = MaxWidth / 8;

  function automatic logic [MaxWidth-1:0] merge_bytes(input logic [MaxWidth-1:0] old_word,
                                                      input logic [MaxWidth-1:0] new_word,
                                                      input logic [MaxBytes-1:0] be);
    logic [MaxWidth-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MaxBytes; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer for param_regfile. It sweeps entries 0..DEPTH-1 and clears one per cycle.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear_req   : start a sweep (ignored while one is running)
//   busy        : sweep in progress
//   clear_en    : zero entry clear_idx at the coming edge
//   clear_idx   : entry being cleared
module regfile_clear_seq
  import param_regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output logic          busy,
  output logic          clear_en,
  output logic [AW-1:0] clear_idx
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clear_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign clear_idx = cnt_q;

endmodule

// File: rtl/param_regfile.sv
// Parametrised register file. It has two combinational read ports and one synchronous write
// port with byte enables. Two features are optional: a hardwired zero entry and write-to-read
// bypass. A built-in sequencer clears the whole array on request.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset (clears all entries)
//   wr_en/addr/data/be     : write port; wr_be bit i covers wr_data[8i+7:8i]
//   rd_addr0/1, rd_data0/1 : combinational read ports
//   clear_req              : start a full-array clear sweep
//   busy                   : clear sweep in progress (writes are discarded meanwhile)
//   wr_drop                : registered pulse, previous cycle's write was discarded by a sweep
module param_regfile
  import param_regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [AW-1:0]      rd_addr0,
  output logic [WIDTH-1:0]   rd_data0,
  input  logic [AW-1:0]      rd_addr1,
  output logic [WIDTH-1:0]   rd_data1,
  input  logic               clear_req,
  output logic               busy,
  output logic               wr_drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_drop_q;
  logic             clear_en;
  logic [AW-1:0]    clear_idx;
  logic             wr_accept;
  logic [WIDTH-1:0] wr_merged;
  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  // An address selects real storage only if it is in range and is not the hardwired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clear_en  (clear_en),
    .clear_idx (clear_idx)
  );

  assign wr_accept = wr_en && !busy && addr_ok(wr_addr);
  assign wr_merged = WIDTH'(merge_bytes(MaxWidth'(mem_q[wr_addr]), MaxWidth'(wr_data),
                                        MaxBytes'(wr_be)));

  // The sweep and accepted writes never coincide, because writes are only accepted while idle.
  always_comb begin
    mem_d = mem_q;
    if (clear_en) begin
      mem_d[clear_idx] = '0;
    end else if (wr_accept) begin
      mem_d[wr_addr] = wr_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_drop_q <= wr_en && busy;
    end
  end

  assign wr_drop = wr_drop_q;

  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;

  // The bypass path uses wr_merged. An accepted write is always to a valid address, so it
  // matches the storage lookup for that port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = addr_ok(rd_addr[p]) ? mem_q[rd_addr[p]] : '0;
      if (BYPASS && wr_accept && (wr_addr == rd_addr[p])) rd_data[p] = wr_merged;
    end
  end

  assign rd_data0 = rd_data[0];
  assign rd_data1 = rd_data[1];

endmodule

// File: tb/tb_param_regfile.sv
module tb_param_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, clear_req;
  logic [4:0]  wr_addr, rd_addr0, rd_addr1;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic        a_busy, a_drop, b_busy, b_drop;

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Instance A: 32 entries, bypass on. Instance B: 20 entries, bypass off. Same stimulus.
  param_regfile #(
    .WIDTH    (32),
    .DEPTH    (32),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut_a (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_addr0  (rd_addr0),
    .rd_data0  (a_rd0),
    .rd_addr1  (rd_addr1),
    .rd_data1  (a_rd1),
    .clear_req (clear_req),
    .busy      (a_busy),
    .wr_drop   (a_drop)
  );

  param_regfile #(
    .WIDTH    (32),
    .DEPTH    (20),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b0)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_addr0  (rd_addr0),
    .rd_data0  (b_rd0),
    .rd_addr1  (rd_addr1),
    .rd_data1  (b_rd1),
    .clear_req (clear_req),
    .busy      (b_busy),
    .wr_drop   (b_drop)
  );

  // Reference model: one word array per instance, plus the sweep position and drop flag.
  logic [31:0] mem_m  [2][32];
  int          dep    [2];
  bit          byp    [2];
  bit          busy_m [2];
  int          idx_m  [2];
  bit          drop_m [2];

  function automatic logic [31:0] merge_m(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask |= 32'hFF << (8 * i);
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic bit accepts(int d);
    return wr_en && !busy_m[d] && (int'(wr_addr) < dep[d]) && (wr_addr != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic [4:0] a);
    logic [31:0] v;
    if (int'(a) >= dep[d] || a == 5'd0) return 32'h0;
    v = mem_m[d][a];
    if (byp[d] && accepts(d) && wr_addr == a) v = merge_m(v, wr_data, wr_be);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mem_m[d][i] = 32'h0;
      busy_m[d] = 1'b0;
      idx_m[d]  = 0;
      drop_m[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit acc;
      bit was_busy;
      acc      = accepts(d);
      was_busy = busy_m[d];
      if (acc) mem_m[d][wr_addr] = merge_m(mem_m[d][wr_addr], wr_data, wr_be);
      drop_m[d] = wr_en && was_busy;
      if (was_busy) begin
        mem_m[d][idx_m[d]] = 32'h0;
        idx_m[d]++;
        if (idx_m[d] == dep[d]) busy_m[d] = 1'b0;
      end else if (clear_req) begin
        busy_m[d] = 1'b1;
        idx_m[d]  = 0;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #1;
    chk("a_rd0", a_rd0, exp_rd(0, rd_addr0));
    chk("a_rd1", a_rd1, exp_rd(0, rd_addr1));
    chk("b_rd0", b_rd0, exp_rd(1, rd_addr0));
    chk("b_rd1", b_rd1, exp_rd(1, rd_addr1));
    chk("a_busy", 32'(a_busy), 32'(busy_m[0]));
    chk("b_busy", 32'(b_busy), 32'(busy_m[1]));
    chk("a_drop", 32'(a_drop), 32'(drop_m[0]));
    chk("b_drop", 32'(b_drop), 32'(drop_m[1]));
  endtask

  // Entered in the low phase with inputs set; leaves at the next falling edge.
  task automatic cycle();
    check_all();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic set_wr(logic en, logic [4:0] a, logic [31:0] dat, logic [3:0] be);
    wr_en   = en;
    wr_addr = a;
    wr_data = dat;
    wr_be   = be;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    dep[0] = 32; dep[1] = 20;
    byp[0] = 1'b1; byp[1] = 1'b0;
    reset = 1'b1;
    clear_req = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    rd_addr0 = 5'd3;
    rd_addr1 = 5'd19;
    model_reset();

    // Reset state
    @(negedge clk);
    check_all();
    reset = 1'b0;
    cycle();

    // Basic write/read
    set_wr(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
    cycle();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    rd_addr0 = 5'd5;
    rd_addr1 = 5'd6;
    #1;
    chk("basic_rd0", a_rd0, 32'hDEADBEEF);
    chk("basic_rd1", a_rd1, 32'h0);
    cycle();

    // Byte merge
    set_wr(1'b1, 5'd3, 32'h11223344, 4'hF);
    cycle();
    set_wr(1'b1, 5'd3, 32'hAABBCCDD, 4'h5);
    cycle();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    rd_addr0 = 5'd3;
    #1;
    chk("merge_a", a_rd0, 32'h11BB33DD);
    chk("merge_b", b_rd0, 32'h11BB33DD);
    cycle();

    // Zero register
    set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
    cycle();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    rd_addr0 = 5'd0;
    rd_addr1 = 5'd0;
    #1;
    chk("zero_a", a_rd0, 32'h0);
    chk("zero_b", b_rd1, 32'h0);
    cycle();

    // Bypass: forwarded on A, old value on B
    set_wr(1'b1, 5'd7, 32'h12345678, 4'hF);
    rd_addr0 = 5'd7;
    #1;
    chk("bypass_a", a_rd0, 32'h12345678);
    chk("nobypass_b", b_rd0, 32'h0);
    cycle();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    chk("after_wr_b", b_rd0, 32'h12345678);
    cycle();

    // Clear sweep
    for (int i = 0; i < 32; i++) begin
      set_wr(1'b1, 5'(i), 32'hA5A5A5A5, 4'hF);
      cycle();
    end
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    busy_cnt = 0;
    for (int m = 0; m < 35; m++) begin
      set_wr(m == 5, 5'd25, 32'h11111111, 4'hF);
      rd_addr0 = 5'd25;
      rd_addr1 = 5'd10;
      #1;
      busy_cnt += int'(a_busy);
      chk("sweep_e10", a_rd1, (m >= 11) ? 32'h0 : 32'hA5A5A5A5);
      if (m == 6) begin
        chk("sweep_drop", 32'(a_drop), 32'h1);
        chk("sweep_e25", a_rd0, 32'hA5A5A5A5);
      end
      if (m == 7) chk("sweep_drop_clr", 32'(a_drop), 32'h0);
      cycle();
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd32);

    // Reset mid-sweep
    for (int i = 1; i < 32; i++) begin
      set_wr(1'b1, 5'(i), 32'h5A5A0000 | 32'(i), 4'hF);
      cycle();
    end
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    for (int m = 0; m < 12; m++) cycle();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_busy_a", 32'(a_busy), 32'h0);
    chk("rst_busy_b", 32'(b_busy), 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i);
      rd_addr1 = 5'(31 - i);
      #1;
      chk("rst_rd0", a_rd0, 32'h0);
      chk("rst_rd1", a_rd1, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    set_wr(1'b1, 5'd4, 32'hCAFEF00D, 4'hF);
    cycle();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    rd_addr0 = 5'd4;
    #1;
    chk("post_rst_wr", a_rd0, 32'hCAFEF00D);
    cycle();

    // Out-of-range on the 20-entry instance
    set_wr(1'b1, 5'd25, 32'h77777777, 4'hF);
    rd_addr1 = 5'd25;
    cycle();
    set_wr(1'b0, 5'd0, 32'h0, 4'h0);
    #1;
    chk("oor_drop_b", 32'(b_drop), 32'h0);
    chk("oor_rd_b", b_rd1, 32'h0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_wr($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
             4'($urandom_range(0, 15)));
      rd_addr0  = 5'($urandom_range(0, 31));
      rd_addr1  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      clear_req = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
